// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-style instruction fields into 32-bit words and writes them to instruction memory.
module instr_encoder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_class,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENCODE = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic [4:0]        r_rs, r_rt, r_rd, r_shamt;
  logic [5:0]        r_funct;
  logic [15:0]       r_imm;
  logic [25:0]       r_target;
  logic              r_last;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       w_word;
  logic              w_last_slot;
  assign w_last_slot = r_ptr == ADDR_W'(DEPTH - 1);
  always_comb begin
    w_word = {6'b000000, r_rs, r_rt, r_rd, r_shamt, r_funct};
    case (r_op)
      3'd1: w_word = {6'b000100, r_rs, r_rt, r_imm};
      3'd2: w_word = {6'b101011, r_rs, r_rt, r_imm};
      3'd3: w_word = {6'b100011, r_rs, r_rt, r_imm};
      3'd4: w_word = {6'b001000, r_rs, r_rt, r_imm};
      3'd5: w_word = {6'b000010, r_target};
      3'd6: w_word = {6'b000011, r_rs, r_rt, r_imm};
      3'd7: w_word = {6'b001111, 5'd0, r_rt, r_imm};
      default: w_word = {6'b000000, r_rs, r_rt, r_rd, r_shamt, r_funct};
    endcase
  end
  // The pointer parks on the last slot so it never wraps; count alone reaches DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (restart) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op     <= op_class;
          r_rs     <= rs;
          r_rt     <= rt;
          r_rd     <= rd;
          r_shamt  <= shamt;
          r_funct  <= funct;
          r_imm    <= imm;
          r_target <= target;
          r_last   <= last;
          r_state  <= S_ENCODE;
        end
        S_ENCODE: begin
          r_wdata <= w_word;
          r_addr  <= r_ptr;
          r_we    <= 1'b1;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_we    <= 1'b0;
          r_count <= r_count + 1'b1;
          r_ptr   <= w_last_slot ? r_ptr : r_ptr + 1'b1;
          r_state <= (r_last || w_last_slot) ? S_DONE : S_IDLE;
        end
        default: r_state <= S_DONE;
      endcase
    end
  end
  assign in_ready  = r_state == S_IDLE;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign done      = r_state == S_DONE;
  assign full      = r_count == (ADDR_W + 1)'(DEPTH);
endmodule
